// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//   Turns one flash request (4KB sector erase, 64KB block erase, chip erase, page program)
//   into the Avalon transfer sequence on the FlashBusInterface CNTRL slave:
//   WREN, ADDR load, DATA fill (program only), operation command, then READ_SR busy-poll.
//   Completion is reported only after the flash BUSY bit reads back clear.
//
// Ports
//   i_Clk, i_Reset          clock, synchronous active-high reset
//   i_Req_*/o_Req_Ready     request handshake (op, byte address, program length)
//   i_Wr_*/o_Wr_Ready       program data byte stream
//   o_Busy/o_Done/o_Error   status; o_Error qualifies the one-cycle o_Done pulse
//   o_AV_*/i_AV_*           Avalon master towards the CNTRL slave

module flash_op_sequencer #(
    parameter int unsigned POLL_LIMIT = 65535,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Req_Valid,
    output logic              o_Req_Ready,
    input  logic [1:0]        i_Req_Op,
    input  logic [ADDR_W-1:0] i_Req_Addr,
    input  logic [8:0]        i_Req_Len,
    input  logic [7:0]        i_Wr_Data,
    input  logic              i_Wr_Valid,
    output logic              o_Wr_Ready,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic              o_AV_SlaveSel,
    output logic [1:0]        o_AV_RegAddr,
    output logic [3:0]        o_AV_ByteEn,
    output logic              o_AV_Read,
    output logic              o_AV_Write,
    output logic [31:0]       o_AV_WriteData,
    input  logic [31:0]       i_AV_ReadData,
    input  logic              i_AV_WaitRequest
);

    localparam int unsigned PollW = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);

    localparam logic [1:0]  RegCntrl    = 2'd0;
    localparam logic [1:0]  RegAddr     = 2'd1;
    localparam logic [1:0]  RegData     = 2'd2;
    localparam logic [1:0]  OpChipErase = 2'd2;
    localparam logic [1:0]  OpProgram   = 2'd3;
    localparam logic [31:0] CntrlWren   = 32'h0000_0100;  // start bit + WREN
    localparam logic [31:0] CntrlRdsr   = 32'h0000_0106;  // start bit + RDSR

    typedef enum logic [3:0] {
        StIdle,
        StWren,
        StWaitC,
        StAddr,
        StData,
        StCmd,
        StRdsr,
        StSrRd,
        StDone
    } state_t;

    state_t            r_State;
    state_t            r_RetState;   // where StWaitC resumes once the controller is idle
    logic [1:0]        r_Op;
    logic [ADDR_W-1:0] r_Addr;
    logic [8:0]        r_Len;
    logic [8:0]        r_ByteCnt;
    logic [PollW-1:0]  r_PollCnt;

    logic              r_ReqReady;
    logic              r_Busy;
    logic              r_Done;
    logic              r_Error;
    logic              r_WrReady;
    logic              r_Read;
    logic              r_Write;
    logic [1:0]        r_RegAddr;
    logic [3:0]        r_ByteEn;
    logic [31:0]       r_WriteData;

    // Erase/program command codes are SE=1, BE=2, CE=3, PP=4, i.e. op + 1.
    logic [3:0] w_OpCode;
    assign w_OpCode = {2'b00, r_Op} + 4'd1;

    // Only the controller-busy and flash-BUSY bits of read data matter.
    logic w_ReadData_unused;
    assign w_ReadData_unused = ^{i_AV_ReadData[31:10], i_AV_ReadData[8:1]};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State     <= StIdle;
            r_RetState  <= StIdle;
            r_Op        <= '0;
            r_Addr      <= '0;
            r_Len       <= '0;
            r_ByteCnt   <= '0;
            r_PollCnt   <= '0;
            r_ReqReady  <= 1'b1;
            r_Busy      <= 1'b0;
            r_Done      <= 1'b0;
            r_Error     <= 1'b0;
            r_WrReady   <= 1'b0;
            r_Read      <= 1'b0;
            r_Write     <= 1'b0;
            r_RegAddr   <= '0;
            r_ByteEn    <= '0;
            r_WriteData <= '0;
        end else begin
            r_Done  <= 1'b0;
            r_Error <= 1'b0;
            case (r_State)
                StIdle: begin
                    if (i_Req_Valid && r_ReqReady) begin
                        r_Op       <= i_Req_Op;
                        r_Addr     <= i_Req_Addr;
                        r_Len      <= i_Req_Len;
                        r_ByteCnt  <= '0;
                        r_PollCnt  <= '0;
                        r_ReqReady <= 1'b0;
                        if (i_Req_Op == OpProgram && (i_Req_Len == 9'd0 || i_Req_Len > 9'd256)) begin
                            // Illegal length: finish immediately without touching the bus.
                            r_Busy  <= 1'b0;
                            r_Done  <= 1'b1;
                            r_Error <= 1'b1;
                            r_State <= StDone;
                        end else begin
                            r_Busy  <= 1'b1;
                            r_State <= StWren;
                        end
                    end
                end

                StWren: begin
                    if (!r_Write) begin
                        r_Write     <= 1'b1;
                        r_RegAddr   <= RegCntrl;
                        r_ByteEn    <= 4'hF;
                        r_WriteData <= CntrlWren;
                    end else if (!i_AV_WaitRequest) begin
                        r_Write    <= 1'b0;
                        r_RetState <= (r_Op == OpChipErase) ? StCmd : StAddr;
                        r_State    <= StWaitC;
                    end
                end

                StWaitC: begin
                    if (!r_Read) begin
                        r_Read    <= 1'b1;
                        r_RegAddr <= RegCntrl;
                        r_ByteEn  <= 4'hF;
                    end else if (!i_AV_WaitRequest) begin
                        r_Read <= 1'b0;
                        if (!i_AV_ReadData[9]) begin
                            r_State <= r_RetState;
                        end
                    end
                end

                StAddr: begin
                    if (!r_Write) begin
                        r_Write     <= 1'b1;
                        r_RegAddr   <= RegAddr;
                        r_ByteEn    <= 4'hF;
                        r_WriteData <= 32'(r_Addr);
                    end else if (!i_AV_WaitRequest) begin
                        r_Write <= 1'b0;
                        if (r_Op == OpProgram) begin
                            r_WrReady <= 1'b1;
                            r_State   <= StData;
                        end else begin
                            r_State <= StCmd;
                        end
                    end
                end

                StData: begin
                    // Ready is offered only while no DATA write is outstanding.
                    if (r_WrReady) begin
                        if (i_Wr_Valid) begin
                            r_WrReady   <= 1'b0;
                            r_Write     <= 1'b1;
                            r_RegAddr   <= RegData;
                            r_ByteEn    <= 4'h1;
                            r_WriteData <= {24'h0, i_Wr_Data};
                            r_ByteCnt   <= r_ByteCnt + 9'd1;
                        end
                    end else if (r_Write && !i_AV_WaitRequest) begin
                        r_Write <= 1'b0;
                        if (r_ByteCnt == r_Len) begin
                            r_State <= StCmd;
                        end else begin
                            r_WrReady <= 1'b1;
                        end
                    end
                end

                StCmd: begin
                    if (!r_Write) begin
                        r_Write     <= 1'b1;
                        r_RegAddr   <= RegCntrl;
                        r_ByteEn    <= 4'hF;
                        r_WriteData <= {23'h0, 1'b1, 4'h0, w_OpCode};
                    end else if (!i_AV_WaitRequest) begin
                        r_Write    <= 1'b0;
                        r_RetState <= StRdsr;
                        r_State    <= StWaitC;
                    end
                end

                StRdsr: begin
                    if (!r_Write) begin
                        r_Write     <= 1'b1;
                        r_RegAddr   <= RegCntrl;
                        r_ByteEn    <= 4'hF;
                        r_WriteData <= CntrlRdsr;
                    end else if (!i_AV_WaitRequest) begin
                        r_Write    <= 1'b0;
                        r_RetState <= StSrRd;
                        r_State    <= StWaitC;
                    end
                end

                StSrRd: begin
                    if (!r_Read) begin
                        r_Read    <= 1'b1;
                        r_RegAddr <= RegData;
                        r_ByteEn  <= 4'hF;
                    end else if (!i_AV_WaitRequest) begin
                        r_Read <= 1'b0;
                        if (!i_AV_ReadData[0]) begin
                            r_Busy  <= 1'b0;
                            r_Done  <= 1'b1;
                            r_State <= StDone;
                        end else if (r_PollCnt == PollW'(POLL_LIMIT)) begin
                            r_Busy  <= 1'b0;
                            r_Done  <= 1'b1;
                            r_Error <= 1'b1;
                            r_State <= StDone;
                        end else begin
                            r_PollCnt <= r_PollCnt + 1'b1;
                            r_State   <= StRdsr;
                        end
                    end
                end

                StDone: begin
                    r_ReqReady <= 1'b1;
                    r_State    <= StIdle;
                end

                default: begin
                    r_State <= StIdle;
                end
            endcase
        end
    end

    assign o_Req_Ready    = r_ReqReady;
    assign o_Wr_Ready     = r_WrReady;
    assign o_Busy         = r_Busy;
    assign o_Done         = r_Done;
    assign o_Error        = r_Error;
    assign o_AV_Read      = r_Read;
    assign o_AV_Write     = r_Write;
    assign o_AV_SlaveSel  = r_Read | r_Write;
    assign o_AV_RegAddr   = r_RegAddr;
    assign o_AV_ByteEn    = r_ByteEn;
    assign o_AV_WriteData = r_WriteData;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// tb_flash_op_sequencer
//   Randomized bench for flash_op_sequencer. A behavioural Avalon slave with random stalls and
//   random controller/flash busy responses logs every completed transfer; after each request the
//   log is compared with the write sequence derived from the request and the busy profile.

module tb_flash_op_sequencer;

    localparam int PL    = 8;
    localparam int STUCK = 1000000;

    logic        r_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Req_Valid;
    logic        o_Req_Ready;
    logic [1:0]  i_Req_Op;
    logic [23:0] i_Req_Addr;
    logic [8:0]  i_Req_Len;
    logic [7:0]  i_Wr_Data = 8'h0;
    logic        i_Wr_Valid = 1'b0;
    logic        o_Wr_Ready;
    logic        o_Busy;
    logic        o_Done;
    logic        o_Error;
    logic        o_AV_SlaveSel;
    logic [1:0]  o_AV_RegAddr;
    logic [3:0]  o_AV_ByteEn;
    logic        o_AV_Read;
    logic        o_AV_Write;
    logic [31:0] o_AV_WriteData;
    logic [31:0] i_AV_ReadData = 32'h0;
    logic        i_AV_WaitRequest = 1'b0;

    always #5 r_Clk = ~r_Clk;

    flash_op_sequencer #(
        .POLL_LIMIT(PL),
        .ADDR_W    (24)
    ) dut (
        .i_Clk           (r_Clk),
        .i_Reset         (i_Reset),
        .i_Req_Valid     (i_Req_Valid),
        .o_Req_Ready     (o_Req_Ready),
        .i_Req_Op        (i_Req_Op),
        .i_Req_Addr      (i_Req_Addr),
        .i_Req_Len       (i_Req_Len),
        .i_Wr_Data       (i_Wr_Data),
        .i_Wr_Valid      (i_Wr_Valid),
        .o_Wr_Ready      (o_Wr_Ready),
        .o_Busy          (o_Busy),
        .o_Done          (o_Done),
        .o_Error         (o_Error),
        .o_AV_SlaveSel   (o_AV_SlaveSel),
        .o_AV_RegAddr    (o_AV_RegAddr),
        .o_AV_ByteEn     (o_AV_ByteEn),
        .o_AV_Read       (o_AV_Read),
        .o_AV_Write      (o_AV_Write),
        .o_AV_WriteData  (o_AV_WriteData),
        .i_AV_ReadData   (i_AV_ReadData),
        .i_AV_WaitRequest(i_AV_WaitRequest)
    );

    typedef struct {
        bit        wr;
        bit [1:0]  ra;
        bit [3:0]  be;
        bit [31:0] d;
    } xfer_t;

    int        checkCnt = 0;
    int        failCnt  = 0;
    xfer_t     logQ[$];
    bit [7:0]  bytes[256];

    // Slave/feeder shared state
    int        minStall = 0;
    int        maxStall = 0;
    int        stallLeft = 0;
    bit        inXfer = 0;
    bit        stalled = 0;
    bit [39:0] heldBundle = '0;
    int        cntrlBusyLeft = 0;
    int        srBusyLeft = 0;
    int        srReads = 0;
    bit        waitC = 0;
    bit        feedOn = 0;
    int        feedIdx = 0;
    int        feedLen = 0;
    bit        seenReady = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finishRun();
        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    endtask

    // Avalon slave: acts 2 time units after each rising edge.
    always @(posedge r_Clk) begin : slave
        bit [39:0] cur;
        bit [31:0] rd;
        #2;
        cur = {o_AV_Read, o_AV_Write, o_AV_RegAddr, o_AV_ByteEn, o_AV_WriteData};
        if (i_Reset) begin
            inXfer           = 0;
            stalled          = 0;
            i_AV_WaitRequest = 1'b0;
        end else begin
            checkVal("slave_sel", 64'(o_AV_SlaveSel), 64'(o_AV_Read | o_AV_Write));
            if (stalled) checkVal("stall_hold", 64'(cur), 64'(heldBundle));
            stalled = 0;
            if (o_AV_Read || o_AV_Write) begin
                if (!inXfer) begin
                    inXfer    = 1;
                    stallLeft = $urandom_range(maxStall, minStall);
                end
                if (stallLeft > 0) begin
                    stallLeft--;
                    i_AV_WaitRequest = 1'b1;
                    i_AV_ReadData    = $urandom;
                    stalled          = 1;
                    heldBundle       = cur;
                end else begin
                    xfer_t x;
                    inXfer = 0;
                    i_AV_WaitRequest = 1'b0;
                    rd = $urandom;
                    x.wr = o_AV_Write;
                    x.ra = o_AV_RegAddr;
                    x.be = o_AV_ByteEn;
                    x.d  = o_AV_WriteData;
                    if (o_AV_Write) begin
                        checkVal("wait_ctrl_idle", 64'(waitC), 64'd0);
                        if (o_AV_RegAddr == 2'd0) begin
                            waitC         = 1;
                            cntrlBusyLeft = $urandom_range(2, 0);
                        end
                    end else if (o_AV_RegAddr == 2'd0) begin
                        rd[9] = (cntrlBusyLeft > 0);
                        if (cntrlBusyLeft > 0) cntrlBusyLeft--;
                        if (!rd[9]) waitC = 0;
                    end else begin
                        checkVal("wait_ctrl_idle", 64'(waitC), 64'd0);
                        rd[0] = (srBusyLeft > 0);
                        if (srBusyLeft > 0) srBusyLeft--;
                        srReads++;
                    end
                    i_AV_ReadData = rd;
                    logQ.push_back(x);
                end
            end else begin
                i_AV_WaitRequest = 1'b0;
                i_AV_ReadData    = $urandom;
            end
        end
    end

    // Program byte source with random gaps.
    always @(posedge r_Clk) begin : feeder
        #2;
        if (i_Wr_Valid && seenReady) feedIdx++;
        if (feedOn && feedIdx < feedLen && $urandom_range(3, 0) != 0) begin
            i_Wr_Valid = 1'b1;
            i_Wr_Data  = bytes[feedIdx];
        end else begin
            i_Wr_Valid = 1'b0;
            i_Wr_Data  = 8'($urandom);
        end
        seenReady = o_Wr_Ready;
    end

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
    endtask

    task automatic waitReady();
        for (int c = 0; c < 2000 && !o_Req_Ready; c++) @(negedge r_Clk);
        if (!o_Req_Ready) begin
            checkVal("ready_timeout", 64'(o_Req_Ready), 64'd1);
            finishRun();
        end
    endtask

    task automatic issueReq(input logic [1:0] op, input logic [23:0] addr, input int len,
                            input int busyPolls, input int stMin, input int stMax);
        waitReady();
        logQ.delete();
        srReads       = 0;
        waitC         = 0;
        cntrlBusyLeft = 0;
        srBusyLeft    = busyPolls;
        minStall      = stMin;
        maxStall      = stMax;
        feedIdx       = 0;
        feedLen       = (len > 256) ? 256 : len;
        feedOn        = (op == 2'd3);
        i_Req_Valid   = 1'b1;
        i_Req_Op      = op;
        i_Req_Addr    = addr;
        i_Req_Len     = 9'(len);
        @(negedge r_Clk);
        i_Req_Valid   = 1'b0;
    endtask

    // One request end to end; expectations follow from the request and the busy profile.
    task automatic runOp(input logic [1:0] op, input logic [23:0] addr, input int len,
                         input int busyPolls, input int stMin, input int stMax, input bit junk);
        bit    badLen;
        bit    expErr;
        int    nRdsr;
        int    c;
        xfer_t expW[$];
        xfer_t gotW[$];
        badLen = (op == 2'd3) && (len == 0 || len > 256);
        issueReq(op, addr, len, busyPolls, stMin, stMax);
        if (badLen) begin
            checkVal("badlen_done", 64'(o_Done), 64'd1);
            checkVal("badlen_err", 64'(o_Error), 64'd1);
            checkVal("badlen_strobe", 64'({o_AV_Read, o_AV_Write}), 64'd0);
            @(negedge r_Clk);
            checkVal("badlen_pulse", 64'(o_Done), 64'd0);
            checkVal("badlen_ready", 64'(o_Req_Ready), 64'd1);
            checkVal("badlen_traffic", 64'(logQ.size()), 64'd0);
            feedOn = 0;
            return;
        end
        checkVal("busy_after_accept", 64'(o_Busy), 64'd1);
        checkVal("ready_low", 64'(o_Req_Ready), 64'd0);
        if (junk) begin
            for (int j = 0; j < 3; j++) begin
                i_Req_Valid = 1'b1;
                i_Req_Op    = 2'($urandom);
                i_Req_Addr  = 24'($urandom);
                i_Req_Len   = 9'($urandom);
                @(negedge r_Clk);
                checkVal("busy_no_accept", 64'(o_Req_Ready), 64'd0);
            end
            i_Req_Valid = 1'b0;
        end
        c = 0;
        while (!o_Done && c < 20000) begin
            @(negedge r_Clk);
            c++;
        end
        if (!o_Done) begin
            checkVal("done_timeout", 64'(o_Done), 64'd1);
            finishRun();
        end
        expErr = (busyPolls > PL);
        nRdsr  = expErr ? PL + 1 : busyPolls + 1;
        checkVal("done_err", 64'(o_Error), 64'(expErr));
        checkVal("done_busy", 64'(o_Busy), 64'd0);

        expW.push_back('{wr: 1, ra: 2'd0, be: 4'hF, d: 32'h100});
        if (op != 2'd2) expW.push_back('{wr: 1, ra: 2'd1, be: 4'hF, d: {8'h0, addr}});
        if (op == 2'd3) begin
            for (int i = 0; i < len; i++) begin
                expW.push_back('{wr: 1, ra: 2'd2, be: 4'h1, d: {24'h0, bytes[i]}});
            end
        end
        expW.push_back('{wr: 1, ra: 2'd0, be: 4'hF, d: 32'h100 + 32'(op) + 32'd1});
        for (int i = 0; i < nRdsr; i++) expW.push_back('{wr: 1, ra: 2'd0, be: 4'hF, d: 32'h106});

        foreach (logQ[i]) if (logQ[i].wr) gotW.push_back(logQ[i]);
        checkVal("write_count", 64'(gotW.size()), 64'(expW.size()));
        for (int i = 0; i < gotW.size() && i < expW.size(); i++) begin
            // CNTRL byte enables are not constrained; compare them elsewhere only.
            checkVal($sformatf("write%0d", i),
                     64'({gotW[i].ra, (gotW[i].ra == 2'd0) ? 4'h0 : gotW[i].be, gotW[i].d}),
                     64'({expW[i].ra, (expW[i].ra == 2'd0) ? 4'h0 : expW[i].be, expW[i].d}));
        end
        checkVal("sr_reads", 64'(srReads), 64'(nRdsr));

        @(negedge r_Clk);
        checkVal("done_pulse", 64'(o_Done), 64'd0);
        checkVal("ready_idle", 64'(o_Req_Ready), 64'd1);
        feedOn = 0;
    endtask

    initial begin
        int op;
        int len;
        i_Reset     = 1'b1;
        i_Req_Valid = 1'b0;
        i_Req_Op    = 2'd0;
        i_Req_Addr  = 24'h0;
        i_Req_Len   = 9'd0;
        repeat (3) @(negedge r_Clk);
        checkVal("rst_ready", 64'(o_Req_Ready), 64'd1);
        checkVal("rst_outputs", 64'({o_Busy, o_Done, o_Error, o_Wr_Ready, o_AV_SlaveSel,
                 o_AV_Read, o_AV_Write, o_AV_RegAddr, o_AV_ByteEn, o_AV_WriteData}), 64'd0);
        i_Reset = 1'b0;
        @(negedge r_Clk);
        checkVal("idle_ready", 64'(o_Req_Ready), 64'd1);

        // Sector erase, three busy polls, no stalls
        fillRandom();
        runOp(2'd0, 24'h001000, 1, 3, 0, 0, 0);

        // Page program of four known bytes
        bytes[0] = 8'hAA;
        bytes[1] = 8'hBB;
        bytes[2] = 8'hCC;
        bytes[3] = 8'hDD;
        runOp(2'd3, 24'h000004, 4, 0, 0, 1, 0);

        // Every transfer stalled five cycles
        runOp(2'd1, 24'h12_3456, 0, 2, 5, 5, 1);
        fillRandom();
        runOp(2'd3, 24'hABCDEF, 5, 1, 5, 5, 0);

        // Illegal program lengths
        runOp(2'd3, 24'h000100, 0, 0, 0, 0, 0);
        runOp(2'd3, 24'h000100, 257, 0, 0, 0, 0);

        // Poll-limit boundaries
        runOp(2'd0, 24'h00F000, 9, STUCK, 0, 1, 0);
        runOp(2'd1, 24'h010000, 9, PL, 0, 1, 0);
        runOp(2'd0, 24'h020000, 9, PL + 1, 0, 1, 0);

        // Full page
        fillRandom();
        runOp(2'd3, 24'h300000, 256, 1, 0, 1, 0);

        // Chip erase aborted by reset during the status poll
        issueReq(2'd2, 24'h0, 0, STUCK, 0, 2);
        for (int c = 0; c < 5000 && srReads == 0; c++) @(negedge r_Clk);
        checkVal("reset_reached_poll", 64'(srReads > 0), 64'd1);
        i_Reset = 1'b1;
        @(negedge r_Clk);
        i_Reset = 1'b0;
        checkVal("abort_strobes", 64'({o_AV_SlaveSel, o_AV_Read, o_AV_Write}), 64'd0);
        checkVal("abort_status", 64'({o_Req_Ready, o_Busy, o_Done, o_Error, o_Wr_Ready}),
                 64'b10000);
        runOp(2'd2, 24'h0, 0, 1, 0, 2, 0);

        // Random mix
        for (int n = 0; n < 24; n++) begin
            fillRandom();
            op = $urandom_range(3, 0);
            if ($urandom_range(9, 0) == 0) len = $urandom_range(1, 0) ? 0 : $urandom_range(511, 257);
            else len = $urandom_range(24, 1);
            runOp(2'(op), 24'($urandom), len, $urandom_range(10, 0), 0, $urandom_range(3, 0),
                  1'($urandom));
        end

        finishRun();
    end

endmodule
